// File: rtl/i2s_sound_test_pkg.sv
// Shared constants, sample type and slot serializer helper for the I2S square-tone source.
package i2s_sound_test_pkg;

  localparam int FRAME_BITS  = 64;
  localparam int SLOT_BITS   = 32;
  localparam int SAMPLE_BITS = 16;
  localparam int MSB_POS     = 1;

  typedef logic signed [SAMPLE_BITS-1:0] sample_t;

  // Bit driven at slot position pos: MSB one bit after the WS edge, zero padding elsewhere.
  function automatic logic slot_bit(input logic [4:0] pos, input sample_t sample);
    logic [3:0] idx;
    slot_bit = 1'b0;
    idx = 4'(5'(MSB_POS + SAMPLE_BITS - 1) - pos);
    if (pos >= 5'(MSB_POS) && pos < 5'(MSB_POS + SAMPLE_BITS)) begin
      slot_bit = sample[idx];
    end
  endfunction

endpackage

// File: rtl/i2s_square_tone.sv
// Square-wave sample source: counts frames, flips polarity every half period, latches one sample per frame.
module i2s_square_tone
  import i2s_sound_test_pkg::*;
#(
  parameter sample_t SAMPLE_AMPLITUDE   = 16'sh2000,
  parameter int      HALF_PERIOD_FRAMES = 24
) (
  input  logic    serial_clk,
  input  logic    reset,
  input  logic    frame_tick,
  output sample_t sample
);

  localparam int              FC_W          = 10;
  localparam logic [FC_W-1:0] LAST_FRAME    = FC_W'(HALF_PERIOD_FRAMES - 1);
  localparam sample_t         NEG_AMPLITUDE = -SAMPLE_AMPLITUDE;

  logic [FC_W-1:0] frame_count_reg, frame_count_next;
  logic            negative_reg, negative_next;
  sample_t         sample_reg, sample_next;

  always_comb begin
    frame_count_next = frame_count_reg;
    negative_next    = negative_reg;
    sample_next      = sample_reg;
    if (frame_tick) begin
      if (frame_count_reg == LAST_FRAME) begin
        frame_count_next = '0;
        negative_next    = ~negative_reg;
      end else begin
        frame_count_next = frame_count_reg + 10'd1;
      end
      // The new polarity applies to the frame that starts on this tick.
      sample_next = negative_next ? NEG_AMPLITUDE : SAMPLE_AMPLITUDE;
    end
  end

  always_ff @(posedge serial_clk) begin
    if (reset) begin
      frame_count_reg <= '0;
      negative_reg    <= 1'b0;
      sample_reg      <= SAMPLE_AMPLITUDE;
    end else begin
      frame_count_reg <= frame_count_next;
      negative_reg    <= negative_next;
      sample_reg      <= sample_next;
    end
  end

  assign sample = sample_reg;

endmodule

// File: rtl/i2s_sound_test.sv
// I2S test-tone transmitter: 64-bit frame counter, WS generation and a position-indexed serializer mux.
module i2s_sound_test
  import i2s_sound_test_pkg::*;
#(
  parameter sample_t SAMPLE_AMPLITUDE   = 16'sh2000,
  parameter int      HALF_PERIOD_FRAMES = 24
) (
  input  logic       serial_clk,
  input  logic       reset,
  output logic       word_select,
  output logic       sound_bit_out,
  output logic [5:0] bit_counter
);

  logic [5:0] count_reg, count_next;
  logic       ws_reg, ws_next;
  logic       bit_reg, bit_next;
  logic       frame_tick;
  sample_t    sample;

  // Natural 6-bit wrap gives 63 -> 0 with no idle cycle.
  assign count_next = count_reg + 6'd1;
  assign frame_tick = (count_reg == 6'(FRAME_BITS - 1));

  // Outputs are computed from the next count so all three registers agree in every cycle.
  assign ws_next  = (count_next >= 6'(SLOT_BITS));
  assign bit_next = slot_bit(count_next[4:0], sample);

  i2s_square_tone #(
    .SAMPLE_AMPLITUDE  (SAMPLE_AMPLITUDE),
    .HALF_PERIOD_FRAMES(HALF_PERIOD_FRAMES)
  ) u_tone (
    .serial_clk(serial_clk),
    .reset     (reset),
    .frame_tick(frame_tick),
    .sample    (sample)
  );

  always_ff @(posedge serial_clk) begin
    if (reset) begin
      count_reg <= '0;
      ws_reg    <= 1'b0;
      bit_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      ws_reg    <= ws_next;
      bit_reg   <= bit_next;
    end
  end

  assign bit_counter   = count_reg;
  assign word_select   = ws_reg;
  assign sound_bit_out = bit_reg;

endmodule

// File: tb/tb_i2s_sound_test.sv
// Scoreboard bench: stimulus queues expected per-frame samples, an I2S receiver monitor decodes and compares.
module tb_i2s_sound_test;

  logic       serial_clk = 1'b0;
  logic       reset      = 1'b1;
  logic [1:0] ws;
  logic [1:0] sd;
  logic [5:0] bc [2];

  logic       zero_req     = 1'b0;
  logic       done         = 1'b0;
  logic       wait_timeout = 1'b0;

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];

  int checks = 0;
  int passed = 0;

  // Receiver state per DUT
  logic        in_frame [2];
  int          exp_bc   [2];
  int          frame_no [2];
  logic [15:0] left     [2];
  logic [15:0] right    [2];
  logic        pad_err  [2];
  logic        ws_err   [2];
  logic        seq_err  [2];

  always #5 serial_clk = ~serial_clk;

  i2s_sound_test dut_a (
    .serial_clk   (serial_clk),
    .reset        (reset),
    .word_select  (ws[0]),
    .sound_bit_out(sd[0]),
    .bit_counter  (bc[0])
  );

  i2s_sound_test #(
    .SAMPLE_AMPLITUDE  (16'sh7FFF),
    .HALF_PERIOD_FRAMES(1)
  ) dut_b (
    .serial_clk   (serial_clk),
    .reset        (reset),
    .word_select  (ws[1]),
    .sound_bit_out(sd[1]),
    .bit_counter  (bc[1])
  );

  task automatic check(input string name, input int dut, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s dut%0d: got %h, expected %h", name, dut, act, req);
  endtask

  task automatic push_frames(input int n);
    for (int k = 0; k < n; k++) begin
      exp_q0.push_back(((k / 24) % 2) != 0 ? 16'hE000 : 16'h2000);
      exp_q1.push_back((k % 2) != 0 ? 16'h8001 : 16'h7FFF);
    end
  endtask

  // Stimulus
  initial begin
    reset = 1'b1;
    repeat (3) @(posedge serial_clk);
    #1 zero_req = 1'b1;
    @(posedge serial_clk);
    #1 zero_req = 1'b0;
    push_frames(50);
    reset = 1'b0;
    repeat (50 * 64) @(posedge serial_clk);
    #1;
    begin : find_40
      for (int c = 0; c < 200; c++) begin
        if (bc[0] == 6'd40) disable find_40;
        @(posedge serial_clk);
        #1;
      end
      wait_timeout = 1'b1;
    end
    reset = 1'b1;
    @(posedge serial_clk);
    #1 zero_req = 1'b1;
    @(posedge serial_clk);
    #1 zero_req = 1'b0;
    push_frames(200);
    reset = 1'b0;
    repeat (200 * 64) @(posedge serial_clk);
    #1 done = 1'b1;
  end

  // Monitor / passive I2S receiver
  always @(negedge serial_clk) begin
    if (done) begin
      check("queue0 drained", 0, exp_q0.size(), 32'd0);
      check("queue1 drained", 1, exp_q1.size(), 32'd0);
      check("reached bit 40 before reset", 0, {31'd0, wait_timeout}, 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (zero_req) check("reset outputs", i, {24'd0, ws[i], sd[i], bc[i]}, 32'd0);
        if (reset !== 1'b0) begin
          in_frame[i] = 1'b0;
          frame_no[i] = 0;
        end else begin
          if (bc[i] == 6'd0) begin
            in_frame[i] = 1'b1;
            exp_bc[i]   = 0;
            left[i]     = '0;
            right[i]    = '0;
            pad_err[i]  = 1'b0;
            ws_err[i]   = 1'b0;
            seq_err[i]  = 1'b0;
          end
          if (in_frame[i]) begin
            if (bc[i] !== 6'(exp_bc[i])) seq_err[i] = 1'b1;
            if (ws[i] !== (exp_bc[i] >= 32)) ws_err[i] = 1'b1;
            if ((exp_bc[i] % 32) >= 1 && (exp_bc[i] % 32) <= 16) begin
              if (exp_bc[i] < 32) left[i]  = {left[i][14:0], sd[i]};
              else                right[i] = {right[i][14:0], sd[i]};
            end else if (sd[i] !== 1'b0) begin
              pad_err[i] = 1'b1;
            end
            exp_bc[i]++;
            if (exp_bc[i] == 64) begin
              logic [15:0] exp_s;
              exp_s = 'x;
              if (i == 0) begin
                if (exp_q0.size() > 0) exp_s = exp_q0.pop_front();
              end else begin
                if (exp_q1.size() > 0) exp_s = exp_q1.pop_front();
              end
              $display("dut%0d frame %0d left=%h right=%h expected=%h", i, frame_no[i], left[i], right[i], exp_s);
              check("left sample", i, {16'd0, left[i]}, {16'd0, exp_s});
              check("right sample", i, {16'd0, right[i]}, {16'd0, exp_s});
              check("padding bits zero", i, {31'd0, pad_err[i]}, 32'd0);
              check("word_select slot", i, {31'd0, ws_err[i]}, 32'd0);
              check("bit_counter sequence", i, {31'd0, seq_err[i]}, 32'd0);
              in_frame[i] = 1'b0;
              frame_no[i]++;
            end
          end
        end
      end
    end
  end

endmodule
